// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames DBITS data bits with optional parity and
// one or two stop bits, timed by oversample ticks from a shared baud timer.
module uart_tx_ctrl #(
    parameter int DBITS    = 8,
    parameter int OS_TICKS = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_tick,
    output logic       tmr_en,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic       two_stop,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int              SW     = (OS_TICKS > 1) ? $clog2(OS_TICKS) : 1;
    localparam logic [SW-1:0]   S_LAST = SW'(OS_TICKS - 1);
    localparam logic [2:0]      N_LAST = 3'(DBITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_cnt_q, s_cnt_d;
    logic [2:0]      n_cnt_q, n_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_en_q, par_en_d;
    logic            par_bit_q, par_bit_d;
    logic            two_stop_q, two_stop_d;
    logic            tx_q, tx_d;
    logic            tx_done_q, tx_done_d;
    logic            bit_end;

    // Parity is resolved once at accept so the shifting data need not be kept.
    function automatic logic parity_bit(input logic [7:0] d, input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < DBITS; i++) begin
            p = p ^ d[i];
        end
        return p;
    endfunction

    assign bit_end = s_tick && (s_cnt_q == S_LAST);

    always_comb begin
        state_d    = state_q;
        s_cnt_d    = s_cnt_q;
        n_cnt_d    = n_cnt_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        tx_done_d  = 1'b0;
        tx_d       = 1'b1;

        if (state_q != IDLE && s_tick) begin
            s_cnt_d = bit_end ? '0 : s_cnt_q + SW'(1);
        end

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d    = START;
                    shift_d    = tx_data;
                    par_en_d   = parity_en;
                    par_bit_d  = parity_bit(tx_data, parity_odd);
                    two_stop_d = two_stop;
                    s_cnt_d    = '0;
                    n_cnt_d    = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    n_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (n_cnt_q == N_LAST) begin
                        n_cnt_d = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        n_cnt_d = n_cnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    n_cnt_d = '0;
                end
            end
            STOP: begin
                // n_cnt marks the first of two stop bits when two_stop is latched.
                if (bit_end) begin
                    if (two_stop_q && n_cnt_q == 3'd0) begin
                        n_cnt_d = 3'd1;
                    end else begin
                        state_d   = IDLE;
                        n_cnt_d   = '0;
                        tx_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // tx is registered from the next state so the start bit appears on the accept edge.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_bit_q;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            s_cnt_q    <= '0;
            n_cnt_q    <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_cnt_q    <= s_cnt_d;
            n_cnt_q    <= n_cnt_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_done  = tx_done_q;
    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign tmr_en   = (state_q != IDLE);

endmodule
